dynamic_branch_predictor: RTL
=============================

// Module: dynamic_branch_predictor
// PURPOSE
//  Parametrised successor to the fixed 8-entry fetch-stage predictor: 2-bit saturating BHT plus tagged BTB.
//  Serves the Fetch stage, with a combinational lookup on PC_curr.
//  Trained synchronously from Decode with resolved outcome and target.
//  Adds tag compare, BTB valid bits, configurable depth/width and saturating performance counters.
// PARAMETERS
//  PC_W    16  PC / target width in bits
//  IDX_W   3   index bits; BHT and BTB each hold 2**IDX_W entries
//  TAG_W   4   BTB tag bits, taken from PC[IDX_W+TAG_W:IDX_W+1]
//  STAT_W  16  width of each performance counter
//  GHR_W   IDX_W  global history length (used only with DBP_GSHARE_EN)
// PORTS
//  clk                 in   1        clock
//  rst_n               in   1        synchronous active-low reset
//  PC_curr             in   PC_W     fetch PC being predicted
//  prediction          out  2        BHT counter at lookup index
//  btb_hit             out  1        BTB entry valid and tag equal
//  predict_taken       out  1        prediction[1] & btb_hit
//  predicted_target    out  PC_W     BTB target on hit, else PC_curr+2
//  wen_BHT             in   1        train BHT (resolved branch in Decode)
//  wen_BTB             in   1        write BTB entry
//  IF_ID_PC_curr       in   PC_W     PC of the branch being resolved
//  IF_ID_prediction    in   2        counter value sampled at that branch's fetch
//  actual_taken        in   1        resolved direction
//  actual_target       in   PC_W     resolved target
//  update_PC           in   1        misprediction flush seen by Decode (statistics only)
//  branch_cnt          out  STAT_W   number of wen_BHT cycles
//  taken_cnt           out  STAT_W   number of wen_BHT & actual_taken cycles
//  mispredict_cnt      out  STAT_W   number of update_PC cycles
// BEHAVIOUR
//  Lookup:
//   - idx = PC_curr[IDX_W:1] (halfword aligned); zero-cycle combinational read.
//   - prediction, btb_hit, predicted_target and predict_taken depend only on the arrays and PC_curr.
//  Training (posedge clk, rst_n=1):
//   - uidx = IF_ID_PC_curr[IDX_W:1].
//   - wen_BHT: BHT[uidx] <= sat(IF_ID_prediction +/- 1).
//     Increment on actual_taken, otherwise decrement.
//     Clamp at 2'b11 and 2'b00.
//     The new value is computed from IF_ID_prediction, not from a re-read of BHT.
//   - wen_BTB: BTB[uidx] <= {valid=1, tag(IF_ID_PC_curr), actual_target}.
//   - wen_BHT and wen_BTB are independent; both may fire in the same cycle.
//  Read/write collision:
//   - If uidx==idx in the same cycle, the lookup returns the pre-write contents.
//   - The new contents are visible from the next cycle (no bypass).
//  Arithmetic:
//   - PC_curr+2 wraps modulo 2**PC_W; all-ones-1 gives 0.
//   - Tag compare covers exactly TAG_W bits.
//   - PC bits above IDX_W+TAG_W are ignored (aliasing allowed).
//  Counters:
//   - Increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
//   - update_PC increments mispredict_cnt even when wen_BHT=0.
//  Reset (rst_n=0 at posedge):
//   - Every BHT entry resets to 2'b00.
//   - Every BTB valid bit resets to 0; BTB tag and target reset to 0.
//   - All counters reset to 0; GHR resets to 0.
//   - Reset wins over a simultaneous wen_*.
//   - Outputs after reset: prediction=2'b00, btb_hit=0, predict_taken=0, predicted_target=PC_curr+2.
//   - Reset mid-training discards the pending write.
// CONFIGURATION
//  DBP_GSHARE_EN defined:
//   - Adds a GHR_W-bit global history register.
//   - Adds ports pred_ghr (out, GHR_W) and IF_ID_ghr (in, GHR_W).
//   - pred_ghr = current GHR.
//   - BHT lookup index = PC_curr[IDX_W:1] ^ GHR.
//   - BHT train index = IF_ID_PC_curr[IDX_W:1] ^ IF_ID_ghr.
//   - On wen_BHT: GHR <= {IF_ID_ghr[GHR_W-2:0], actual_taken}, i.e. history is repaired from the resolved branch.
//   - The BTB index never uses the GHR.
//  DBP_GSHARE_EN undefined: no GHR and no extra ports; pure PC-indexed bimodal behaviour as above.
// TESTING
//  - Reset: rst_n=0 for one cycle, then PC_curr=16'h0004 -> prediction=00, btb_hit=0, predicted_target=16'h0006.
//  - Saturation up: three wen_BHT cycles with actual_taken=1 at IF_ID_PC_curr=16'h0004,
//    feeding back the prior prediction each time -> 01, 10, 11.
//    A fourth taken cycle with IF_ID_prediction=11 -> stays 11.
//  - BTB tag: write 16'h0004 -> target 16'h0020.
//    Lookup 16'h0004 -> hit, target 16'h0020.
//    Lookup 16'h0014 (same idx, different tag) -> btb_hit=0, target 16'h0016.
//  - Collision: wen_BTB for 16'h0008 -> 16'h0030 while PC_curr=16'h0008 -> btb_hit=0 that cycle, 1 the next.
//  - Wrap and counters: PC_curr=16'hFFFE with a miss -> predicted_target=16'h0000.
//    With STAT_W=2 and 5 update_PC pulses -> mispredict_cnt=2'b11.
//  - DBP_GSHARE_EN: taken branches at 16'h0002 and 16'h0004 -> GHR=3'b011.
//    Lookup 16'h0002 then indexes entry 1^3=2.

Source files
------------

// File: rtl/dynamic_branch_predictor_if.sv
// Fetch/Decode-facing signal bundle of the dynamic branch predictor.
// DBP_GSHARE_EN adds the global-history exchange signals.
interface dynamic_branch_predictor_if #(
  parameter int PC_W   = 16,
  parameter int STAT_W = 16,
  parameter int GHR_W  = 3
);
  logic [PC_W-1:0]   PC_curr;
  logic [1:0]        prediction;
  logic              btb_hit;
  logic              predict_taken;
  logic [PC_W-1:0]   predicted_target;
  logic              wen_BHT;
  logic              wen_BTB;
  logic [PC_W-1:0]   IF_ID_PC_curr;
  logic [1:0]        IF_ID_prediction;
  logic              actual_taken;
  logic [PC_W-1:0]   actual_target;
  logic              update_PC;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] taken_cnt;
  logic [STAT_W-1:0] mispredict_cnt;
`ifdef DBP_GSHARE_EN
  logic [GHR_W-1:0]  pred_ghr;
  logic [GHR_W-1:0]  IF_ID_ghr;

  modport master (
    output PC_curr, wen_BHT, wen_BTB, IF_ID_PC_curr, IF_ID_prediction,
           actual_taken, actual_target, update_PC, IF_ID_ghr,
    input  prediction, btb_hit, predict_taken, predicted_target,
           branch_cnt, taken_cnt, mispredict_cnt, pred_ghr
  );

  modport slave (
    input  PC_curr, wen_BHT, wen_BTB, IF_ID_PC_curr, IF_ID_prediction,
           actual_taken, actual_target, update_PC, IF_ID_ghr,
    output prediction, btb_hit, predict_taken, predicted_target,
           branch_cnt, taken_cnt, mispredict_cnt, pred_ghr
  );
`else
  modport master (
    output PC_curr, wen_BHT, wen_BTB, IF_ID_PC_curr, IF_ID_prediction,
           actual_taken, actual_target, update_PC,
    input  prediction, btb_hit, predict_taken, predicted_target,
           branch_cnt, taken_cnt, mispredict_cnt
  );

  modport slave (
    input  PC_curr, wen_BHT, wen_BTB, IF_ID_PC_curr, IF_ID_prediction,
           actual_taken, actual_target, update_PC,
    output prediction, btb_hit, predict_taken, predicted_target,
           branch_cnt, taken_cnt, mispredict_cnt
  );
`endif
endinterface

// File: rtl/dynamic_branch_predictor.sv
// 2-bit saturating BHT plus tagged BTB with combinational fetch lookup and Decode-side training.
// Define DBP_GSHARE_EN to XOR a global history register into the BHT index (gshare).
module dynamic_branch_predictor #(
  parameter int PC_W   = 16,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 4,
  parameter int STAT_W = 16,
  parameter int GHR_W  = IDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dynamic_branch_predictor_if.slave  bus
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        r_bht       [DEPTH];
  logic              r_btbValid  [DEPTH];
  logic [TAG_W-1:0]  r_btbTag    [DEPTH];
  logic [PC_W-1:0]   r_btbTarget [DEPTH];
  logic [STAT_W-1:0] r_branchCnt;
  logic [STAT_W-1:0] r_takenCnt;
  logic [STAT_W-1:0] r_mispredictCnt;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_uidx;
  logic [IDX_W-1:0]  w_bhtIdx;
  logic [IDX_W-1:0]  w_bhtUidx;
  logic [TAG_W-1:0]  w_tag;
  logic [TAG_W-1:0]  w_utag;
  logic              w_hit;
  logic [1:0]        w_bhtNext;

  assign w_idx  = bus.PC_curr[IDX_W:1];
  assign w_uidx = bus.IF_ID_PC_curr[IDX_W:1];
  assign w_tag  = bus.PC_curr[IDX_W+TAG_W:IDX_W+1];
  assign w_utag = bus.IF_ID_PC_curr[IDX_W+TAG_W:IDX_W+1];

`ifdef DBP_GSHARE_EN
  logic [GHR_W-1:0] r_ghr;
  logic             w_unusedGhr;

  assign w_bhtIdx    = w_idx ^ IDX_W'(r_ghr);
  assign w_bhtUidx   = w_uidx ^ IDX_W'(bus.IF_ID_ghr);
  assign bus.pred_ghr = r_ghr;
  assign w_unusedGhr = bus.IF_ID_ghr[GHR_W-1];
`else
  assign w_bhtIdx  = w_idx;
  assign w_bhtUidx = w_uidx;
`endif

  // Bits outside the index and tag fields are deliberately aliased away.
  logic w_unusedPcBits;
  assign w_unusedPcBits = ^{bus.PC_curr[0], bus.IF_ID_PC_curr[0],
                            bus.PC_curr[PC_W-1:IDX_W+TAG_W+1],
                            bus.IF_ID_PC_curr[PC_W-1:IDX_W+TAG_W+1]};

  assign w_hit                = r_btbValid[w_idx] && (r_btbTag[w_idx] == w_tag);
  assign bus.prediction       = r_bht[w_bhtIdx];
  assign bus.btb_hit          = w_hit;
  assign bus.predict_taken    = r_bht[w_bhtIdx][1] & w_hit;
  assign bus.predicted_target = w_hit ? r_btbTarget[w_idx] : bus.PC_curr + PC_W'(2);
  assign bus.branch_cnt       = r_branchCnt;
  assign bus.taken_cnt        = r_takenCnt;
  assign bus.mispredict_cnt   = r_mispredictCnt;

  // Training is based on the counter seen at fetch time, not a fresh BHT read.
  always_comb begin
    w_bhtNext = bus.IF_ID_prediction;
    if (bus.actual_taken) begin
      if (bus.IF_ID_prediction != 2'b11) w_bhtNext = bus.IF_ID_prediction + 2'b01;
    end else begin
      if (bus.IF_ID_prediction != 2'b00) w_bhtNext = bus.IF_ID_prediction - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bht[i]       <= 2'b00;
        r_btbValid[i]  <= 1'b0;
        r_btbTag[i]    <= '0;
        r_btbTarget[i] <= '0;
      end
      r_branchCnt     <= '0;
      r_takenCnt      <= '0;
      r_mispredictCnt <= '0;
`ifdef DBP_GSHARE_EN
      r_ghr <= '0;
`endif
    end else begin
      if (bus.wen_BHT) begin
        r_bht[w_bhtUidx] <= w_bhtNext;
`ifdef DBP_GSHARE_EN
        r_ghr <= {bus.IF_ID_ghr[GHR_W-2:0], bus.actual_taken};
`endif
      end
      if (bus.wen_BTB) begin
        r_btbValid[w_uidx]  <= 1'b1;
        r_btbTag[w_uidx]    <= w_utag;
        r_btbTarget[w_uidx] <= bus.actual_target;
      end
      // Statistics saturate instead of wrapping.
      if (bus.wen_BHT && (r_branchCnt != '1))
        r_branchCnt <= r_branchCnt + STAT_W'(1);
      if (bus.wen_BHT && bus.actual_taken && (r_takenCnt != '1))
        r_takenCnt <= r_takenCnt + STAT_W'(1);
      if (bus.update_PC && (r_mispredictCnt != '1))
        r_mispredictCnt <= r_mispredictCnt + STAT_W'(1);
    end
  end
endmodule
